// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers of the EX stage.
// Results are computed when an op is accepted and committed after a fixed busy window.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    input  logic        rd_sel,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] D
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   pendHi_q, pendHi_d;
    logic [31:0]   pendLo_q, pendLo_d;
    logic          pendWrite_q, pendWrite_d;

    logic          accept;
    logic          isMultDiv;
    logic [63:0]   prodSigned;
    logic [63:0]   prodUnsigned;
    logic          divSigned;
    logic          aNeg;
    logic          bNeg;
    logic [31:0]   magA;
    logic [31:0]   magB;
    logic [31:0]   divisor;
    logic [31:0]   uQuot;
    logic [31:0]   uRem;
    logic [31:0]   quot;
    logic [31:0]   rem;

    assign accept    = start & ~flush & (state_q == IDLE);
    assign isMultDiv = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);

    assign prodSigned   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prodUnsigned = {32'd0, A} * {32'd0, B};

    // Signed divide works on magnitudes, which keeps 0x80000000 / -1 well defined.
    assign divSigned = (op == OP_DIV);
    assign aNeg      = divSigned & A[31];
    assign bNeg      = divSigned & B[31];
    assign magA      = aNeg ? (~A + 32'd1) : A;
    assign magB      = bNeg ? (~B + 32'd1) : B;
    assign divisor   = (B == 32'd0) ? 32'd1 : magB;
    assign uQuot     = magA / divisor;
    assign uRem      = magA % divisor;
    assign quot      = (aNeg ^ bNeg) ? (~uQuot + 32'd1) : uQuot;
    assign rem       = aNeg ? (~uRem + 32'd1) : uRem;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && isMultDiv) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (count_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == BUSY);
    end

    always_comb begin
        count_d     = count_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        pendHi_d    = pendHi_q;
        pendLo_d    = pendLo_q;
        pendWrite_d = pendWrite_q;
        if (state_q == BUSY) begin
            if (count_q == '0) begin
                if (pendWrite_q) begin
                    hi_d = pendHi_q;
                    lo_d = pendLo_q;
                end
            end else begin
                count_d = count_q - CW'(1);
            end
        end else if (accept) begin
            case (op)
                OP_MULT: begin
                    {pendHi_d, pendLo_d} = prodSigned;
                    pendWrite_d          = 1'b1;
                    count_d              = MULT_LOAD;
                end
                OP_MULTU: begin
                    {pendHi_d, pendLo_d} = prodUnsigned;
                    pendWrite_d          = 1'b1;
                    count_d              = MULT_LOAD;
                end
                OP_DIV, OP_DIVU: begin
                    pendHi_d    = rem;
                    pendLo_d    = quot;
                    pendWrite_d = (B != 32'd0);
                    count_d     = DIV_LOAD;
                end
                OP_MTHI: hi_d = A;
                OP_MTLO: lo_d = A;
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q     <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            pendHi_q    <= '0;
            pendLo_q    <= '0;
            pendWrite_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            pendHi_q    <= pendHi_d;
            pendLo_q    <= pendLo_d;
            pendWrite_q <= pendWrite_d;
        end
    end

    assign HI = hi_q;
    assign LO = lo_q;
    assign D  = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed vector table, corner-case sequences and
// randomized ops checked against an arithmetic reference model.
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        flush;
    logic        rd_sel;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] D;

    int          numChecks;
    int          numFails;
    logic [31:0] modelHi;
    logic [31:0] modelLo;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          busyCycles;
    } vector_t;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .flush  (flush),
        .rd_sel (rd_sel),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO),
        .D      (D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Architectural result of one op, straight from the ISA rules using 64-bit arithmetic.
    task automatic refModel(input logic [2:0] opIn, input logic [31:0] a, input logic [31:0] b,
                            input logic fl, output logic [31:0] hiOut, output logic [31:0] loOut,
                            output int cycles);
        longint          sa, sb, q, r, p;
        longint unsigned ua, ub, uq, ur, up;
        sa     = longint'($signed(a));
        sb     = longint'($signed(b));
        ua     = {32'd0, a};
        ub     = {32'd0, b};
        hiOut  = modelHi;
        loOut  = modelLo;
        cycles = 0;
        if (!fl) begin
            case (opIn)
                3'd1: begin p = sa * sb; hiOut = p[63:32]; loOut = p[31:0]; cycles = 5; end
                3'd2: begin up = ua * ub; hiOut = up[63:32]; loOut = up[31:0]; cycles = 5; end
                3'd3: begin
                    cycles = 10;
                    if (b != 0) begin
                        q = sa / sb; r = sa % sb;
                        hiOut = r[31:0]; loOut = q[31:0];
                    end
                end
                3'd4: begin
                    cycles = 10;
                    if (b != 0) begin
                        uq = ua / ub; ur = ua % ub;
                        hiOut = ur[31:0]; loOut = uq[31:0];
                    end
                end
                3'd5: hiOut = a;
                3'd6: loOut = a;
                default: begin
                end
            endcase
        end
    endtask

    // Called at a falling edge; the op is presented until the next rising edge.
    task automatic applyStimulus(input logic [2:0] opIn, input logic [31:0] a, input logic [31:0] b, input logic fl);
        start = 1'b1;
        op    = opIn;
        A     = a;
        B     = b;
        flush = fl;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'd0;
    endtask

    task automatic runAndCheck(input string name, input logic [2:0] opIn, input logic [31:0] a,
                               input logic [31:0] b, input logic fl, input logic [31:0] expHi,
                               input logic [31:0] expLo, input int cycles);
        applyStimulus(opIn, a, b, fl);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            checkOutput({name, "_busy"}, {31'd0, busy}, 32'd1);
            checkOutput({name, "_hiHold"}, HI, modelHi);
            checkOutput({name, "_loHold"}, LO, modelLo);
        end
        @(negedge clk);
        checkOutput({name, "_idle"}, {31'd0, busy}, 32'd0);
        checkOutput({name, "_hi"}, HI, expHi);
        checkOutput({name, "_lo"}, LO, expLo);
        rd_sel = 1'b0;
        #1;
        checkOutput({name, "_dLo"}, D, expLo);
        rd_sel = 1'b1;
        #1;
        checkOutput({name, "_dHi"}, D, expHi);
        modelHi = expHi;
        modelLo = expLo;
    endtask

    function automatic logic [31:0] pickOperand();
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        vector_t     vectors[$];
        logic [31:0] expHi, expLo;
        int          cycles;
        int          busyCount;
        logic [2:0]  rOp;
        logic [31:0] rA, rB;
        logic        rFl;

        numChecks = 0;
        numFails  = 0;
        modelHi   = 32'd0;
        modelLo   = 32'd0;
        reset     = 1'b0;
        start     = 1'b0;
        op        = 3'd0;
        A         = 32'd0;
        B         = 32'd0;
        flush     = 1'b0;
        rd_sel    = 1'b0;

        vectors.push_back('{"multNeg",   3'd1, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 5});
        vectors.push_back('{"multuBig",  3'd2, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 5});
        vectors.push_back('{"divNeg",    3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10});
        vectors.push_back('{"divuZero",  3'd4, 32'd7,         32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10});
        vectors.push_back('{"divOvf",    3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10});
        vectors.push_back('{"divZero",   3'd3, 32'd5,         32'd0,         32'h0000_0000, 32'h8000_0000, 10});
        vectors.push_back('{"mthi",      3'd5, 32'hCAFE_BABE, 32'd9,         32'hCAFE_BABE, 32'h8000_0000, 0});
        vectors.push_back('{"invalid7",  3'd7, 32'd1,         32'd1,         32'hCAFE_BABE, 32'h8000_0000, 0});
        vectors.push_back('{"invalid0",  3'd0, 32'd3,         32'd3,         32'hCAFE_BABE, 32'h8000_0000, 0});
        vectors.push_back('{"divuMix",   3'd4, 32'd100,       32'd7,         32'd2,         32'd14,        10});
        vectors.push_back('{"multSmall", 3'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd0,         32'd15,        5});

        repeat (2) @(negedge clk);
        checkOutput("resetBusy", {31'd0, busy}, 32'd0);
        checkOutput("resetHi", HI, 32'd0);
        checkOutput("resetLo", LO, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] flushed MTLO followed by real MTLO");
        runAndCheck("mtloFlush", 3'd6, 32'h1234, 32'd0, 1'b1, 32'd0, 32'd0, 0);
        runAndCheck("mtlo", 3'd6, 32'h1234, 32'd0, 1'b0, 32'd0, 32'h1234, 0);

        $display("[TB] directed vector table");
        foreach (vectors[i]) begin
            runAndCheck(vectors[i].name, vectors[i].op, vectors[i].a, vectors[i].b, 1'b0,
                        vectors[i].expHi, vectors[i].expLo, vectors[i].busyCycles);
        end

        $display("[TB] reset during MULT busy cycle 3");
        applyStimulus(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("rstMidBusyBefore", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("rstMidBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstMidHi", HI, 32'd0);
        checkOutput("rstMidLo", LO, 32'd0);
        modelHi = 32'd0;
        modelLo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            checkOutput("rstAfterBusy", {31'd0, busy}, 32'd0);
            checkOutput("rstAfterHi", HI, 32'd0);
            checkOutput("rstAfterLo", LO, 32'd0);
        end

        $display("[TB] start while busy is ignored");
        busyCount = 0;
        applyStimulus(3'd4, 32'd1000, 32'd7, 1'b0);
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (busy) busyCount++;
            if (i == 11) checkOutput("ignBusyFell", {31'd0, busy}, 32'd0);
            if (i == 2) applyStimulus(3'd1, 32'd3, 32'd4, 1'b0);
        end
        checkOutput("ignBusyCount", 32'(busyCount), 32'd10);
        checkOutput("ignHi", HI, 32'd6);
        checkOutput("ignLo", LO, 32'd142);
        modelHi = 32'd6;
        modelLo = 32'd142;

        $display("[TB] randomized back-to-back ops");
        for (int n = 0; n < 40; n++) begin
            rOp = 3'($urandom_range(0, 7));
            rA  = pickOperand();
            rB  = pickOperand();
            rFl = ($urandom_range(0, 7) == 0);
            refModel(rOp, rA, rB, rFl, expHi, expLo, cycles);
            runAndCheck("rand", rOp, rA, rB, rFl, expHi, expLo, cycles);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
